// File: rtl/i2c_reg_seq_if.sv
// Request/response handshake and Wishbone master bus of the I2C register-access sequencer.
interface i2c_reg_seq_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_rd;
   logic [6:0] req_dev;
   logic [7:0] req_reg;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_err;
   logic [2:0] wbm_adr_o;
   logic [7:0] wbm_dat_o;
   logic [7:0] wbm_dat_i;
   logic       wbm_we_o;
   logic       wbm_stb_o;
   logic       wbm_cyc_o;
   logic       wbm_ack_i;

   modport master (
      input  req_valid, req_rd, req_dev, req_reg, req_wdata, wbm_dat_i, wbm_ack_i,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
   );

   modport slave (
      output req_valid, req_rd, req_dev, req_reg, req_wdata, wbm_dat_i, wbm_ack_i,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
   );
endinterface

// File: rtl/i2c_reg_seq.sv
// Register-access engine: expands one I2C register read/write request into the
// Wishbone access sequence of an 8-bit i2c_master_wbs_8 slave, with timeout.
module i2c_reg_seq #(
   parameter logic [15:0] PRESCALE = 16'd250,
   parameter logic [23:0] TIMEOUT  = 24'd500000
) (
   input  logic          clk,
   input  logic          rst,
   i2c_reg_seq_if.master bus
);
   typedef enum logic [3:0] {
      INIT_PL, INIT_PH, IDLE, PUSH_REG, PUSH_DAT, SET_ADR, CMD1, CMD2,
      POLL_ST, CLR_ACK, POLL_DV, RD_DAT, RESP
   } state_t;

   state_t      state_q, state_d;
   logic        cyc_q, cyc_d, we_q, we_d;
   logic [2:0]  adr_q, adr_d;
   logic [7:0]  dat_q, dat_d;
   logic        rd_q, rd_d, saw_busy_q, saw_busy_d;
   logic [6:0]  dev_q, dev_d;
   logic [7:0]  reg_q, reg_d, wdata_q, wdata_d;
   logic [23:0] timer_q, timer_d;
   logic [7:0]  rdata_q, rdata_d;
   logic [1:0]  err_q, err_d;

   logic        acc_we;
   logic [2:0]  acc_adr;
   logic [7:0]  acc_dat;
   logic        in_txn, tmo, ack;

   assign in_txn = !(state_q inside {INIT_PL, INIT_PH, IDLE, RESP});
   assign tmo    = in_txn && (timer_q >= TIMEOUT);
   assign ack    = cyc_q && bus.wbm_ack_i;

   // The single WB access each state performs.
   always_comb begin
      acc_we  = 1'b1;
      acc_adr = 3'd0;
      acc_dat = 8'h00;
      unique case (state_q)
         INIT_PL:  begin acc_adr = 3'd6; acc_dat = PRESCALE[7:0];  end
         INIT_PH:  begin acc_adr = 3'd7; acc_dat = PRESCALE[15:8]; end
         PUSH_REG: begin acc_adr = 3'd4; acc_dat = reg_q;          end
         PUSH_DAT: begin acc_adr = 3'd4; acc_dat = wdata_q;        end
         SET_ADR:  begin acc_adr = 3'd2; acc_dat = {1'b0, dev_q};  end
         CMD1:     begin acc_adr = 3'd3; acc_dat = 8'h05;          end
         CMD2:     begin acc_adr = 3'd3; acc_dat = rd_q ? 8'h13 : 8'h14; end
         POLL_ST:  acc_we = 1'b0;
         CLR_ACK:  acc_dat = 8'h08;
         POLL_DV:  begin acc_we = 1'b0; acc_adr = 3'd5; end
         RD_DAT:   begin acc_we = 1'b0; acc_adr = 3'd4; end
         default:  acc_we = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      we_d       = we_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      rd_d       = rd_q;
      dev_d      = dev_q;
      reg_d      = reg_q;
      wdata_d    = wdata_q;
      saw_busy_d = saw_busy_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      timer_d    = (in_txn && timer_q < TIMEOUT) ? timer_q + 24'd1 : timer_q;

      if (state_q == IDLE) begin
         if (bus.req_valid) begin
            rd_d       = bus.req_rd;
            dev_d      = bus.req_dev;
            reg_d      = bus.req_reg;
            wdata_d    = bus.req_wdata;
            timer_d    = 24'd0;
            saw_busy_d = 1'b0;
            state_d    = PUSH_REG;
         end
      end else if (state_q == RESP) begin
         state_d = IDLE;
      end else if (!cyc_q) begin
         // Timeout is only honoured between accesses, never mid-cycle.
         if (tmo) begin
            state_d = RESP; err_d = 2'd2; rdata_d = 8'h00;
         end else begin
            cyc_d = 1'b1;
            we_d  = acc_we;
            adr_d = acc_adr;
            dat_d = acc_dat;
         end
      end else if (ack) begin
         cyc_d = 1'b0;
         if (tmo) begin
            state_d = RESP; err_d = 2'd2; rdata_d = 8'h00;
         end else begin
            unique case (state_q)
               INIT_PL:  state_d = INIT_PH;
               INIT_PH:  state_d = IDLE;
               PUSH_REG: state_d = rd_q ? SET_ADR : PUSH_DAT;
               PUSH_DAT: state_d = SET_ADR;
               SET_ADR:  state_d = CMD1;
               CMD1:     state_d = CMD2;
               CMD2:     state_d = POLL_ST;
               POLL_ST: begin
                  // Idle before the first busy just means the command has not started yet.
                  if (bus.wbm_dat_i[0]) begin
                     saw_busy_d = 1'b1;
                  end else if (saw_busy_q) begin
                     if (bus.wbm_dat_i[3])  state_d = CLR_ACK;
                     else if (rd_q)         state_d = POLL_DV;
                     else begin
                        state_d = RESP; err_d = 2'd0; rdata_d = 8'h00;
                     end
                  end
               end
               CLR_ACK: begin
                  state_d = RESP; err_d = 2'd1; rdata_d = 8'h00;
               end
               POLL_DV: if (bus.wbm_dat_i[0]) state_d = RD_DAT;
               RD_DAT: begin
                  state_d = RESP; err_d = 2'd0; rdata_d = bus.wbm_dat_i;
               end
               default: state_d = state_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= INIT_PL;
         cyc_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= 3'd0;
         dat_q      <= 8'h00;
         rd_q       <= 1'b0;
         dev_q      <= 7'd0;
         reg_q      <= 8'h00;
         wdata_q    <= 8'h00;
         saw_busy_q <= 1'b0;
         timer_q    <= 24'd0;
         rdata_q    <= 8'h00;
         err_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         rd_q       <= rd_d;
         dev_q      <= dev_d;
         reg_q      <= reg_d;
         wdata_q    <= wdata_d;
         saw_busy_q <= saw_busy_d;
         timer_q    <= timer_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
   assign bus.wbm_adr_o = adr_q;
   assign bus.wbm_dat_o = dat_q;
   assign bus.wbm_we_o  = we_q;
   assign bus.wbm_stb_o = cyc_q;
   assign bus.wbm_cyc_o = cyc_q;
endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: scripted WB status-register model, scoreboard of expected
// WB accesses and responses, table of request vectors plus timeout/reset sequences.
module tb_i2c_reg_seq;
   localparam logic [23:0] TMO = 24'd300;

   logic clk;
   logic rst;

   i2c_reg_seq_if bus();

   i2c_reg_seq #(.PRESCALE(16'd250), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       we;
      logic [2:0] adr;
      logic [7:0] dat;
   } wb_t;

   typedef struct {
      logic [1:0] err;
      logic [7:0] rdata;
   } rsp_t;

   typedef struct {
      logic       rd;
      logic [6:0] dev;
      logic [7:0] rg;
      logic [7:0] wd;
      int         pre;
      int         busy;
      logic       nack;
      int         dvw;
      logic [7:0] rdat;
      logic [1:0] exp_err;
      logic [7:0] exp_rdata;
   } vec_t;

   wb_t  exp_wb[$];
   rsp_t exp_rsp[$];
   int   n_checks;
   int   n_fail;

   int         g_pre, g_busy, g_dvw, st_cnt, dv_cnt;
   logic       g_nack, g_hang;
   logic [7:0] g_rdat;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic wb_t mk(input logic we, input logic [2:0] adr, input logic [7:0] dat);
      wb_t w;
      w.we = we; w.adr = adr; w.dat = dat;
      return w;
   endfunction

   function automatic vec_t mkv(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                                input logic [7:0] wd, input int pre, input int busy,
                                input logic nack, input int dvw, input logic [7:0] rdat,
                                input logic [1:0] ee, input logic [7:0] er);
      vec_t v;
      v.rd = rd; v.dev = dev; v.rg = rg; v.wd = wd; v.pre = pre; v.busy = busy;
      v.nack = nack; v.dvw = dvw; v.rdat = rdat; v.exp_err = ee; v.exp_rdata = er;
      return v;
   endfunction

   // Wishbone side of i2c_master_wbs_8, with scripted status/data-valid responses.
   initial begin : wb_slave
      wb_t        e;
      logic [7:0] rd;
      int         lat;
      logic       aborted;
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 8'h00;
      forever begin
         @(negedge clk);
         if (rst && bus.wbm_cyc_o) begin
            chk("wb_stb_eq_cyc", 32'(bus.wbm_stb_o), 32'd1);
            rd = 8'h00;
            if (!bus.wbm_we_o) begin
               case (bus.wbm_adr_o)
                  3'd0: begin
                     if (g_hang)                       rd = 8'h01;
                     else if (st_cnt < g_pre)          rd = 8'h00;
                     else if (st_cnt < g_pre + g_busy) rd = 8'h01;
                     else                              rd = g_nack ? 8'h08 : 8'h00;
                     st_cnt++;
                  end
                  3'd5: begin
                     rd = (dv_cnt < g_dvw) ? 8'h00 : 8'h01;
                     dv_cnt++;
                  end
                  3'd4:    rd = g_rdat;
                  default: rd = 8'h00;
               endcase
            end
            if (g_hang && !bus.wbm_we_o && bus.wbm_adr_o == 3'd0) begin
               rd = 8'h01;
            end else if (exp_wb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL wb_unexpected: got we=%0b adr=%0d dat=0x%0h expected no access",
                        bus.wbm_we_o, bus.wbm_adr_o, bus.wbm_dat_o);
            end else begin
               e = exp_wb.pop_front();
               chk("wb_we", 32'(bus.wbm_we_o), 32'(e.we));
               chk("wb_adr", 32'(bus.wbm_adr_o), 32'(e.adr));
               if (e.we) chk("wb_dat", 32'(bus.wbm_dat_o), 32'(e.dat));
            end
            lat = $urandom_range(0, 2);
            aborted = 1'b0;
            for (int i = 0; i < lat; i++) begin
               @(negedge clk);
               if (!rst) begin
                  aborted = 1'b1;
                  break;
               end
               chk("wb_cyc_held", 32'(bus.wbm_cyc_o), 32'd1);
            end
            if (!aborted) begin
               bus.wbm_ack_i = 1'b1;
               bus.wbm_dat_i = rd;
               @(negedge clk);
               bus.wbm_ack_i = 1'b0;
               bus.wbm_dat_i = 8'h00;
               if (rst) chk("wb_cyc_drop", 32'(bus.wbm_cyc_o), 32'd0);
            end
         end
      end
   end

   task automatic push_exp(input vec_t v);
      exp_wb.push_back(mk(1'b1, 3'd4, v.rg));
      if (!v.rd) exp_wb.push_back(mk(1'b1, 3'd4, v.wd));
      exp_wb.push_back(mk(1'b1, 3'd2, {1'b0, v.dev}));
      exp_wb.push_back(mk(1'b1, 3'd3, 8'h05));
      exp_wb.push_back(mk(1'b1, 3'd3, v.rd ? 8'h13 : 8'h14));
      if (!g_hang) begin
         for (int i = 0; i < v.pre + v.busy + 1; i++) exp_wb.push_back(mk(1'b0, 3'd0, 8'h00));
         if (v.nack) begin
            exp_wb.push_back(mk(1'b1, 3'd0, 8'h08));
         end else if (v.rd) begin
            for (int i = 0; i < v.dvw + 1; i++) exp_wb.push_back(mk(1'b0, 3'd5, 8'h00));
            exp_wb.push_back(mk(1'b0, 3'd4, 8'h00));
         end
      end
      begin
         rsp_t r;
         r.err = v.exp_err;
         r.rdata = v.exp_rdata;
         exp_rsp.push_back(r);
      end
   endtask

   // Called on a negedge; leaves the request accepted and the fields scrambled.
   task automatic send_req(input vec_t v);
      for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      g_pre = v.pre; g_busy = v.busy; g_nack = v.nack; g_dvw = v.dvw; g_rdat = v.rdat;
      st_cnt = 0;
      dv_cnt = 0;
      push_exp(v);
      bus.req_rd    = v.rd;
      bus.req_dev   = v.dev;
      bus.req_reg   = v.rg;
      bus.req_wdata = v.wd;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_rd    = ~v.rd;
      bus.req_dev   = ~v.dev;
      bus.req_reg   = ~v.rg;
      bus.req_wdata = ~v.wd;
   endtask

   task automatic do_req(input vec_t v, input int budget, output int cyc_n);
      rsp_t r;
      logic seen;
      seen = 1'b0;
      cyc_n = 0;
      send_req(v);
      while (cyc_n < budget) begin
         @(negedge clk);
         cyc_n++;
         if (bus.rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL rsp_wait: got no rsp_valid expected one within %0d cycles", budget);
         exp_wb.delete();
         exp_rsp.delete();
      end else begin
         r = exp_rsp.pop_front();
         chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
         chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
         chk("ready_low_at_rsp", 32'(bus.req_ready), 32'd0);
         chk("wb_seq_done", 32'(exp_wb.size()), 32'd0);
         @(negedge clk);
         chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
         chk("ready_after_rsp", 32'(bus.req_ready), 32'd1);
         chk("rsp_err_held", 32'(bus.rsp_err), 32'(r.err));
         chk("rsp_rdata_held", 32'(bus.rsp_rdata), 32'(r.rdata));
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
      chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
      chk({tag, "_cyc"}, 32'(bus.wbm_cyc_o), 32'd0);
      chk({tag, "_stb"}, 32'(bus.wbm_stb_o), 32'd0);
      chk({tag, "_adr"}, 32'(bus.wbm_adr_o), 32'd0);
      chk({tag, "_dat"}, 32'(bus.wbm_dat_o), 32'd0);
      chk({tag, "_we"}, 32'(bus.wbm_we_o), 32'd0);
   endtask

   task automatic wait_ready(input string tag);
      logic rsp_seen;
      rsp_seen = 1'b0;
      for (int i = 0; i < 50 && !bus.req_ready; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) rsp_seen = 1'b1;
      end
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      chk({tag, "_no_rsp"}, 32'(rsp_seen), 32'd0);
      chk({tag, "_init_seq"}, 32'(exp_wb.size()), 32'd0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got no end of test expected finish before time limit");
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      vec_t vecs[7];
      vec_t v;
      int   n;
      logic found;

      n_checks = 0;
      n_fail   = 0;
      g_hang = 1'b0; g_nack = 1'b0; g_pre = 0; g_busy = 0; g_dvw = 0; g_rdat = 8'h00;
      st_cnt = 0; dv_cnt = 0;
      bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_dev = 7'd0;
      bus.req_reg = 8'h00; bus.req_wdata = 8'h00;

      //              rd   dev    reg    wd     pre busy nack dvw rdat   err  rdata
      vecs[0] = mkv(1'b0, 7'h50, 8'h10, 8'hA5, 1,  3,  1'b0, 0, 8'h00, 2'd0, 8'h00);
      vecs[1] = mkv(1'b1, 7'h50, 8'h10, 8'h00, 0,  2,  1'b0, 2, 8'hA5, 2'd0, 8'hA5);
      vecs[2] = mkv(1'b0, 7'h33, 8'h00, 8'h11, 0,  2,  1'b1, 0, 8'h00, 2'd1, 8'h00);
      vecs[3] = mkv(1'b0, 7'h50, 8'h20, 8'h5A, 2,  1,  1'b0, 0, 8'h00, 2'd0, 8'h00);
      vecs[4] = mkv(1'b1, 7'h33, 8'h01, 8'h00, 0,  1,  1'b1, 0, 8'h77, 2'd1, 8'h00);
      vecs[5] = mkv(1'b1, 7'h7F, 8'hFF, 8'h00, 0,  4,  1'b0, 0, 8'h3C, 2'd0, 8'h3C);
      vecs[6] = mkv(1'b0, 7'h00, 8'hFF, 8'h00, 0,  1,  1'b0, 0, 8'h00, 2'd0, 8'h00);

      rst = 1'b1;
      exp_wb.push_back(mk(1'b1, 3'd6, 8'hFA));
      exp_wb.push_back(mk(1'b1, 3'd7, 8'h00));
      #3 rst = 1'b0;
      #1 chk_outputs_zero("reset");
      repeat (7) @(negedge clk);
      chk("reset_held_cyc", 32'(bus.wbm_cyc_o), 32'd0);
      rst = 1'b1;
      wait_ready("init");

      for (int k = 0; k < 7; k++) do_req(vecs[k], 500, n);

      // Slave stays busy forever: the request must be abandoned with a timeout.
      g_hang = 1'b1;
      v = mkv(1'b1, 7'h50, 8'h10, 8'h00, 0, 0, 1'b0, 0, 8'h99, 2'd2, 8'h00);
      do_req(v, int'(TMO) + 50, n);
      chk("tmo_latency", 32'((n >= int'(TMO)) && (n <= int'(TMO) + 10)), 32'd1);
      g_hang = 1'b0;
      do_req(vecs[0], 500, n);

      // Reset while polling status of a read.
      g_hang = 1'b1;
      v = mkv(1'b1, 7'h50, 8'h10, 8'h00, 0, 0, 1'b0, 0, 8'h00, 2'd0, 8'h00);
      send_req(v);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (bus.wbm_cyc_o && !bus.wbm_we_o && bus.wbm_adr_o == 3'd0) found = 1'b1;
      end
      chk("reached_poll", 32'(found), 32'd1);
      #2 rst = 1'b0;
      #1 chk_outputs_zero("midreset");
      exp_wb.delete();
      exp_rsp.delete();
      g_hang = 1'b0;
      exp_wb.push_back(mk(1'b1, 3'd6, 8'hFA));
      exp_wb.push_back(mk(1'b1, 3'd7, 8'h00));
      repeat (7) @(negedge clk);
      rst = 1'b1;
      wait_ready("reinit");
      do_req(vecs[1], 500, n);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
